pe_result_collector: RTL

//  Drain stage directly downstream of the processing-element array. Round-robin drains the

---
 rtl/pe_pkg.sv | 44 ++++
 rtl/pe_result_collector_rr_arbiter.sv | 32 +++
 rtl/pe_result_collector.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared types, defaults and the round-robin pick helper used by
//            the processing-element result collector.
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int PE_DATA_W   = 32;
    localparam int RR_MAX_REQ  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        READ = 3'd2,
        CAPT = 3'd3,
        HOLD = 3'd4,
        FIN  = 3'd5
    } collector_state_t;

    // First requester at or above ptr, wrapping modulo n; -1 when none.
    // Walks downward so the lowest rotated position overwrites last and wins.
    function automatic int rr_pick(input int ptr, input logic [RR_MAX_REQ-1:0] req,
                                   input int n);
        int idx;
        int pick_idx;
        pick_idx = -1;
        for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    pick_idx = idx;
                end
            end
        end
        return pick_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_result_collector_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotate-priority pick over NUM_PE requests,
//            starting at ptr. Returns the winning index and a found flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import pe_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int IDX_W  = 2
) (
    input  logic [IDX_W-1:0]  ptr,
    input  logic [NUM_PE-1:0] req,
    output logic [IDX_W-1:0]  pick,
    output logic              found
);

    logic [RR_MAX_REQ-1:0] w_req_ext;
    int                    w_pick_int;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NUM_PE-1:0]  = req;
        w_pick_int             = rr_pick(int'(ptr), w_req_ext, NUM_PE);
        found                  = (w_pick_int >= 0);
        pick                   = found ? IDX_W'(w_pick_int) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/pe_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_collector
// Purpose  : Round-robin drain of NUM_PE PE output FIFOs onto one valid/ready
//            stream tagged with source PE and sequence number; pulses done
//            after the programmed number of results. Optional running
//            checksum output enabled by COLLECTOR_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pe_result_collector
    import pe_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int DATA_W = PE_DATA_W,
    parameter int CNT_W  = 32,
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         total,
    input  logic [NUM_PE-1:0]        pe_empty,
    input  logic [NUM_PE*DATA_W-1:0] pe_data,
    output logic [NUM_PE-1:0]        pe_read,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_pe_idx,
    output logic [CNT_W-1:0]         out_seq,
    output logic                     busy,
    output logic                     done
`ifdef COLLECTOR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]        checksum
`endif
);

    collector_state_t  r_state;
    collector_state_t  w_state_next;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_seq;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_out_data;
    logic [IDX_W-1:0]  r_out_pe_idx;
    logic [IDX_W-1:0]  w_pick;
    logic              w_found;
    logic              w_xfer;
    logic [CNT_W-1:0]  w_seq_inc;
    logic [IDX_W-1:0]  w_ptr_next;

    rr_arbiter #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .ptr   (r_ptr),
        .req   (~pe_empty),
        .pick  (w_pick),
        .found (w_found)
    );

    assign w_xfer     = (r_state == HOLD) && out_ready;
    assign w_seq_inc  = r_seq + 1'b1;
    // The PE just served drops to lowest priority on the next scan.
    assign w_ptr_next = (r_sel == IDX_W'(NUM_PE - 1)) ? '0 : r_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = (total == '0) ? FIN : SCAN;
            SCAN: if (w_found) w_state_next = READ;
            READ: w_state_next = CAPT;
            CAPT: w_state_next = HOLD;
            HOLD: if (w_xfer) w_state_next = (w_seq_inc == r_total) ? FIN : SCAN;
            FIN:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        pe_read   = '0;
        out_valid = (r_state == HOLD);
        busy      = (r_state != IDLE);
        done      = (r_state == FIN);
        if (r_state == READ) begin
            pe_read[r_sel] = 1'b1;
        end
    end

    // FIFO read data arrives the cycle after the strobe, i.e. during CAPT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total      <= '0;
            r_seq        <= '0;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_out_data   <= '0;
            r_out_pe_idx <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_total <= total;
                r_seq   <= '0;
            end
            if ((r_state == SCAN) && w_found) begin
                r_sel <= w_pick;
            end
            if (r_state == CAPT) begin
                r_out_data   <= pe_data[int'(r_sel) * DATA_W +: DATA_W];
                r_out_pe_idx <= r_sel;
            end
            if (w_xfer) begin
                r_seq <= w_seq_inc;
                r_ptr <= w_ptr_next;
            end
        end
    end

`ifdef COLLECTOR_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + r_out_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign out_data   = r_out_data;
    assign out_pe_idx = r_out_pe_idx;
    assign out_seq    = r_seq;

endmodule
`default_nettype wire
